// File: rtl/tlul_csr_host_pkg.sv
// Local types and constants for the TL-UL CSR host.
package tlul_csr_host_pkg;

  // Host FSM states; dbg_state exposes the current one
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Cycles spent in D_WAIT before the access is aborted
  localparam int unsigned DefaultTimeoutCycles = 255;

  // CSR accesses are always one 32-bit word: a_size = log2(4 bytes)
  localparam logic [1:0] CsrSizeLog2 = 2'd2;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by hosts and devices on the CSR fabric.
// Only the fields used by the single-beat, 32-bit CSR ports are carried.
package tlul_pkg;

  // A-channel opcodes
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  // D-channel opcodes
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Host to device: A channel plus D-channel ready
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  // Device to host: D channel plus A-channel ready
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_csr_host.sv
// Single-outstanding TL-UL host that turns a simple local request/response
// port into Get / PutFullData / PutPartialData accesses on a CSR device.
//
// Handshakes: the local request is taken on a cycle where req_valid_i and
// req_ready_o are both 1; the TL-UL A beat transfers when a_valid and a_ready
// are both 1 and A fields never change while a_valid waits; a D beat is
// consumed when d_valid and d_ready are both 1; rsp_valid_o is a one-cycle
// pulse with no back-pressure.
module tlul_csr_host
  import tlul_pkg::*;
  import tlul_csr_host_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
  parameter logic [7:0]  SrcIdInit     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output tl_h2d_t     tl_h2d_o,
  input  tl_d2h_t     tl_d2h_i,
  output state_e      dbg_state
);

  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  state_e      state_q;
  logic        req_ready_q;
  logic        a_valid_q;
  logic        d_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  src_q;
  logic [15:0] cnt_q;
  tl_a_op_e    a_opcode_q;
  logic [29:0] word_addr_q;
  logic [31:0] a_data_q;
  logic [3:0]  mask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        timeout_q;

  logic [15:0] cnt_next;
  logic        src_hit;
  tl_d_op_e    exp_d_op;
  logic        unused_addr_bits;

  // Word-aligned accesses only: the byte offset is dropped
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign cnt_next = cnt_q + 16'd1;
  assign src_hit  = tl_d2h_i.d_valid && (tl_d2h_i.d_source == src_q);
  assign exp_d_op = (a_opcode_q == Get) ? AccessAckData : AccessAck;

  // Host FSM: request capture, A beat, D wait with timeout, completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      a_valid_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      src_q       <= SrcIdInit;
      cnt_q       <= 16'd0;
      a_opcode_q  <= Get;
      word_addr_q <= 30'd0;
      a_data_q    <= 32'd0;
      mask_q      <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready_q && req_valid_i) begin
            req_ready_q <= 1'b0;
            a_valid_q   <= 1'b1;
            word_addr_q <= req_addr_i[31:2];
            if (!req_we_i) begin
              a_opcode_q <= Get;
              mask_q     <= 4'hF;
              a_data_q   <= 32'd0;
            end else begin
              a_opcode_q <= (req_be_i == 4'hF) ? PutFullData : PutPartialData;
              mask_q     <= req_be_i;
              a_data_q   <= req_wdata_i;
            end
            state_q <= A_SEND;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        A_SEND: begin
          // a_valid cannot be withdrawn, so there is no timeout here
          if (tl_d2h_i.a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            cnt_q     <= 16'd0;
            state_q   <= D_WAIT;
          end
        end
        D_WAIT: begin
          cnt_q <= cnt_next;
          if (src_hit) begin
            // Beats with another source are consumed and dropped
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= (a_opcode_q == Get) ? tl_d2h_i.d_data : 32'd0;
            err_q       <= tl_d2h_i.d_error | (tl_d2h_i.d_opcode != exp_d_op);
            timeout_q   <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_next == TimeoutLimit) begin
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= 32'd0;
            err_q       <= 1'b1;
            timeout_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // New ID so a late reply to this access is dropped later
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          src_q       <= src_q + 8'd1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Registered state drives every output directly
  always_comb begin
    tl_h2d_o           = '0;
    tl_h2d_o.a_valid   = a_valid_q;
    tl_h2d_o.a_opcode  = a_opcode_q;
    tl_h2d_o.a_size    = CsrSizeLog2;
    tl_h2d_o.a_source  = src_q;
    tl_h2d_o.a_address = {word_addr_q, 2'b00};
    tl_h2d_o.a_mask    = mask_q;
    tl_h2d_o.a_data    = a_data_q;
    tl_h2d_o.d_ready   = d_ready_q;
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = timeout_q;
  assign dbg_state     = state_q;

endmodule
